// File: rtl/mesi_isc_breq_arbiter.sv
// Round-robin arbiter: pops one pending CPU main-bus request per two cycles and,
// unless it is a NOP, writes it into the broadcast FIFO with a fresh broadcast id.
module mesi_isc_breq_arbiter #(
    parameter int unsigned BROAD_TYPE_WIDTH = 2,
    parameter int unsigned BROAD_ID_WIDTH   = 5,
    parameter int unsigned ADDR_WIDTH       = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [3:0]                    breq_valid_array_i,
    input  logic [4*BROAD_TYPE_WIDTH-1:0] breq_type_array_i,
    input  logic [4*ADDR_WIDTH-1:0]       breq_addr_array_i,
    input  logic                          broad_fifo_full_i,
    output logic [3:0]                    breq_fifo_rd_array_o,
    output logic                          broad_fifo_wr_o,
    output logic [BROAD_TYPE_WIDTH-1:0]   broad_type_o,
    output logic [1:0]                    broad_cpu_id_o,
    output logic [BROAD_ID_WIDTH-1:0]     broad_id_o,
    output logic [ADDR_WIDTH-1:0]         broad_addr_o
);

    localparam logic [BROAD_TYPE_WIDTH-1:0] BREQ_TYPE_NOP = '0;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_t;

    state_t                        r_state;
    logic [1:0]                    r_last_grant;
    logic [BROAD_ID_WIDTH-1:0]     r_id_cnt;
    logic [3:0]                    r_rd;
    logic                          r_wr;
    logic [BROAD_TYPE_WIDTH-1:0]   r_type;
    logic [1:0]                    r_cpu_id;
    logic [BROAD_ID_WIDTH-1:0]     r_broad_id;
    logic [ADDR_WIDTH-1:0]         r_addr;

    logic                          w_grant_vld;
    logic [1:0]                    w_grant_idx;
    logic [BROAD_TYPE_WIDTH-1:0]   w_grant_type;
    logic [ADDR_WIDTH-1:0]         w_grant_addr;
    logic                          w_grant_is_nop;

    // Rotating priority: scan last_grant+1 .. last_grant+4; descending loop lets the nearest win.
    always_comb begin
        w_grant_vld = |breq_valid_array_i;
        w_grant_idx = 2'(r_last_grant + 2'd1);
        for (int j = 3; j >= 0; j--) begin
            if (breq_valid_array_i[2'(r_last_grant + 2'(j + 1))]) begin
                w_grant_idx = 2'(r_last_grant + 2'(j + 1));
            end
        end
        w_grant_type   = breq_type_array_i[int'(w_grant_idx) * BROAD_TYPE_WIDTH +: BROAD_TYPE_WIDTH];
        w_grant_addr   = breq_addr_array_i[int'(w_grant_idx) * ADDR_WIDTH +: ADDR_WIDTH];
        w_grant_is_nop = (w_grant_type == BREQ_TYPE_NOP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 2'd3;
            r_id_cnt     <= '0;
            r_rd         <= '0;
            r_wr         <= 1'b0;
            r_type       <= '0;
            r_cpu_id     <= '0;
            r_broad_id   <= '0;
            r_addr       <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_rd <= '0;
                    r_wr <= 1'b0;
                    if (!broad_fifo_full_i && w_grant_vld) begin
                        r_rd         <= 4'(1) << w_grant_idx;
                        r_wr         <= !w_grant_is_nop;
                        r_last_grant <= w_grant_idx;
                        r_state      <= ST_ISSUE;
                        // NOP entries are discarded, so the data outputs keep their last write.
                        if (!w_grant_is_nop) begin
                            r_type     <= w_grant_type;
                            r_cpu_id   <= w_grant_idx;
                            r_addr     <= w_grant_addr;
                            r_broad_id <= r_id_cnt;
                        end
                    end
                end
                ST_ISSUE: begin
                    r_rd    <= '0;
                    r_wr    <= 1'b0;
                    r_state <= ST_IDLE;
                    if (r_wr) begin
                        r_id_cnt <= BROAD_ID_WIDTH'(r_id_cnt + 1'b1);
                    end
                end
                default: begin
                    r_rd    <= '0;
                    r_wr    <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign breq_fifo_rd_array_o = r_rd;
    assign broad_fifo_wr_o      = r_wr;
    assign broad_type_o         = r_type;
    assign broad_cpu_id_o       = r_cpu_id;
    assign broad_id_o           = r_broad_id;
    assign broad_addr_o         = r_addr;

endmodule

// File: tb/tb_mesi_isc_breq_arbiter.sv
// Directed bench for mesi_isc_breq_arbiter: grant order, full back-pressure,
// NOP discard, id wrap and reset during an issue cycle.
module tb_mesi_isc_breq_arbiter;

    logic         clk;
    logic         rst;
    logic [3:0]   valid;
    logic [7:0]   types;
    logic [127:0] addrs;
    logic         full;
    logic [3:0]   rd;
    logic         wr;
    logic [1:0]   btype;
    logic [1:0]   cpu_id;
    logic [4:0]   bid;
    logic [31:0]  baddr;

    int checks   = 0;
    int failures = 0;

    localparam logic [7:0] ALL_WR     = 8'b01_01_01_01;
    localparam logic [7:0] CPU2_NOP   = 8'b01_00_01_01;
    localparam logic [1:0] TYPE_WR    = 2'd1;

    mesi_isc_breq_arbiter #(
        .BROAD_TYPE_WIDTH(2),
        .BROAD_ID_WIDTH  (5),
        .ADDR_WIDTH      (32)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .breq_valid_array_i  (valid),
        .breq_type_array_i   (types),
        .breq_addr_array_i   (addrs),
        .broad_fifo_full_i   (full),
        .breq_fifo_rd_array_o(rd),
        .broad_fifo_wr_o     (wr),
        .broad_type_o        (btype),
        .broad_cpu_id_o      (cpu_id),
        .broad_id_o          (bid),
        .broad_addr_o        (baddr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] addr_of(input int k);
        return 32'hA000_0000 + 32'(k) * 32'h0000_0110;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_strobe(input string tag, input logic [3:0] exp_rd, input logic exp_wr);
        checks++;
        assert (rd === exp_rd) else begin
            failures++;
            $error("FAIL %s rd observed=%b expected=%b", tag, rd, exp_rd);
        end
        checks++;
        assert (wr === exp_wr) else begin
            failures++;
            $error("FAIL %s wr observed=%b expected=%b", tag, wr, exp_wr);
        end
    endtask

    task automatic chk_data(input string tag, input logic [1:0] exp_cpu, input logic [4:0] exp_id,
                            input logic [1:0] exp_type, input logic [31:0] exp_addr);
        checks++;
        assert (cpu_id === exp_cpu) else begin
            failures++;
            $error("FAIL %s cpu_id observed=%0d expected=%0d", tag, cpu_id, exp_cpu);
        end
        checks++;
        assert (bid === exp_id) else begin
            failures++;
            $error("FAIL %s id observed=%0d expected=%0d", tag, bid, exp_id);
        end
        checks++;
        assert (btype === exp_type) else begin
            failures++;
            $error("FAIL %s type observed=%0d expected=%0d", tag, btype, exp_type);
        end
        checks++;
        assert (baddr === exp_addr) else begin
            failures++;
            $error("FAIL %s addr observed=%h expected=%h", tag, baddr, exp_addr);
        end
    endtask

    initial begin
        rst   = 1'b1;
        valid = 4'b0000;
        types = ALL_WR;
        full  = 1'b0;
        for (int k = 0; k < 4; k++) addrs[k*32 +: 32] = addr_of(k);

        // Reset values
        #3;
        chk_strobe("reset", 4'b0000, 1'b0);
        chk_data("reset", 2'd0, 5'd0, 2'd0, 32'd0);
        step();
        step();
        rst = 1'b0;

        // Idle with no requests
        for (int c = 0; c < 10; c++) begin
            step();
            chk_strobe("idle_novalid", 4'b0000, 1'b0);
        end
        chk_data("idle_novalid", 2'd0, 5'd0, 2'd0, 32'd0);

        // All four requesting: round robin from CPU0
        valid = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            step();
            chk_strobe("rr_grant", 4'(1) << (g % 4), 1'b1);
            chk_data("rr_grant", 2'(g % 4), 5'(g), TYPE_WR, addr_of(g % 4));
            step();
            chk_strobe("rr_gap", 4'b0000, 1'b0);
        end
        valid = 4'b0000;
        // last_grant=0, next id=5

        // Full back-pressure
        full  = 1'b1;
        valid = 4'b0010;
        for (int c = 0; c < 4; c++) begin
            step();
            chk_strobe("full_hold", 4'b0000, 1'b0);
        end
        full = 1'b0;
        step();
        chk_strobe("full_release", 4'b0010, 1'b1);
        chk_data("full_release", 2'd1, 5'd5, TYPE_WR, addr_of(1));
        valid = 4'b0000;
        step();
        chk_strobe("full_release_gap", 4'b0000, 1'b0);

        // NOP from CPU2: pop only, data outputs hold
        types = CPU2_NOP;
        valid = 4'b0100;
        step();
        chk_strobe("nop_pop", 4'b0100, 1'b0);
        chk_data("nop_hold", 2'd1, 5'd5, TYPE_WR, addr_of(1));
        valid = 4'b0000;
        types = ALL_WR;
        step();
        chk_strobe("nop_gap", 4'b0000, 1'b0);
        valid = 4'b0001;
        step();
        chk_strobe("after_nop", 4'b0001, 1'b1);
        chk_data("after_nop", 2'd0, 5'd6, TYPE_WR, addr_of(0));
        valid = 4'b0000;
        step();

        // Fresh reset, then 33 grants to see the id wrap
        rst = 1'b1;
        step();
        rst = 1'b0;
        valid = 4'b1111;
        for (int g = 0; g < 33; g++) begin
            step();
            chk_strobe("wrap_grant", 4'(1) << (g % 4), 1'b1);
            chk_data("wrap_grant", 2'(g % 4), 5'(g % 32), TYPE_WR, addr_of(g % 4));
            step();
            chk_strobe("wrap_gap", 4'b0000, 1'b0);
        end
        // last_grant=0, next id=1

        // Reset asserted during an issue cycle
        step();
        chk_strobe("pre_rst_issue", 4'b0010, 1'b1);
        chk_data("pre_rst_issue", 2'd1, 5'd1, TYPE_WR, addr_of(1));
        #2;
        rst = 1'b1;
        #1;
        chk_strobe("rst_mid_issue", 4'b0000, 1'b0);
        chk_data("rst_mid_issue", 2'd0, 5'd0, 2'd0, 32'd0);
        step();
        step();
        rst = 1'b0;
        step();
        chk_strobe("post_rst_grant", 4'b0001, 1'b1);
        chk_data("post_rst_grant", 2'd0, 5'd0, TYPE_WR, addr_of(0));
        valid = 4'b0000;
        step();
        chk_strobe("post_rst_gap", 4'b0000, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
